// File: rtl/ring_ctrl_pkg.sv
// Shared types and default cadence constants for the ring cadence controller.
package ring_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, HOLD} ring_state_e;

  localparam int unsigned ON_CYCLES_DEF  = 4;
  localparam int unsigned OFF_CYCLES_DEF = 3;
  localparam int unsigned MAX_BURSTS_DEF = 2;
  localparam int unsigned MISSED_W       = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_cadence_ctrl_if.sv
// Call-alert bus: call/user controls toward the sequencer, actuator drives and status back.
interface ring_cadence_ctrl_if;
  import ring_ctrl_pkg::*;

  logic                ring;
  logic                vibrate_mode;
  logic                silence;
  logic                answer;
  logic                clear_missed;
  logic                ringer;
  logic                motor;
  logic                missed_call;
  logic                busy;
  logic [MISSED_W-1:0] missed_count;

  modport master (
    output ring, vibrate_mode, silence, answer, clear_missed,
    input  ringer, motor, missed_call, busy, missed_count
  );

  modport slave (
    input  ring, vibrate_mode, silence, answer, clear_missed,
    output ringer, motor, missed_call, busy, missed_count
  );

endinterface

// File: rtl/ring_cadence_timer.sv
// Loadable down-counter shared by the ON and OFF phases; parks at zero and flags expiry.
module ring_cadence_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/ring_cadence_ctrl.sv
// Call-alert sequencer: ON/OFF burst cadence, ringer/motor exclusion, silence/answer, missed-call flag.
// Optional saturating missed-call counter enabled by RING_MISSED_COUNT_EN.
module ring_cadence_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
  parameter int unsigned OFF_CYCLES = OFF_CYCLES_DEF,
  parameter int unsigned MAX_BURSTS = MAX_BURSTS_DEF
) (
  input logic               clk,
  input logic               reset_n,
  ring_cadence_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURSTS + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD    = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD   = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(MAX_BURSTS - 1);

  ring_state_e          state_q, state_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 mute_q, mute_d;
  logic                 ringer_q, ringer_d;
  logic                 motor_q, motor_d;
  logic                 missed_q, missed_d;
  logic                 busy_q, busy_d;
  logic                 tmr_load_c;
  logic [TIMER_W-1:0]   tmr_val_c;
  logic                 tmr_expired_c;

  ring_cadence_timer #(.W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  // Next state; ring loss beats answer, answer beats silence, silence coexists with expiry.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    mute_d     = mute_q;
    missed_d   = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = ON_LOAD;

    if (!bus.ring) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ON;
          tmr_load_c = 1'b1;
          burst_d    = '0;
          mute_d     = 1'b0;
        end
        ON, OFF: begin
          if (bus.answer) begin
            state_d = HOLD;
          end else begin
            if (bus.silence) begin
              mute_d = 1'b1;
            end
            if (tmr_expired_c) begin
              if (state_q == OFF) begin
                state_d    = ON;
                tmr_load_c = 1'b1;
              end else if (burst_q == LAST_BURST) begin
                state_d  = HOLD;
                missed_d = 1'b1;
              end else begin
                state_d    = OFF;
                tmr_load_c = 1'b1;
                tmr_val_c  = OFF_LOAD;
                burst_d    = burst_q + BURST_W'(1);
              end
            end
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end

    ringer_d = (state_d == ON) && !mute_d && !bus.vibrate_mode;
    motor_d  = (state_d == ON) && !mute_d &&  bus.vibrate_mode;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      mute_q   <= 1'b0;
      ringer_q <= 1'b0;
      motor_q  <= 1'b0;
      missed_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      mute_q   <= mute_d;
      ringer_q <= ringer_d;
      motor_q  <= motor_d;
      missed_q <= missed_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ringer      = ringer_q;
  assign bus.motor       = motor_q;
  assign bus.missed_call = missed_q;
  assign bus.busy        = busy_q;

`ifdef RING_MISSED_COUNT_EN
  logic [MISSED_W-1:0] missed_count_q, missed_count_d;

  // Counts in step with the missed_call pulse; a clear wins over a same-cycle increment.
  always_comb begin
    missed_count_d = missed_count_q;
    if (bus.clear_missed) begin
      missed_count_d = '0;
    end else if (missed_d && (missed_count_q != '1)) begin
      missed_count_d = missed_count_q + MISSED_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missed_count_q <= '0;
    end else begin
      missed_count_q <= missed_count_d;
    end
  end

  assign bus.missed_count = missed_count_q;
`else
  logic unused_clear_missed;
  assign unused_clear_missed = bus.clear_missed;
  assign bus.missed_count    = '0;
`endif

endmodule

// File: tb/tb_ring_cadence_ctrl.sv
// Randomized and directed bench for ring_cadence_ctrl against an elapsed-cycle cadence model.
module tb_ring_cadence_ctrl;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int MAX_B = 2;
  localparam int PER   = ON_C + OFF_C;
  localparam int END_K = MAX_B * PER - OFF_C;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ring_cadence_ctrl_if bus ();

  ring_cadence_ctrl #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .MAX_BURSTS (MAX_B)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a call is "elapsed cycles since start"; output is on when inside the ON part of a period.
  bit m_busy, m_hold, m_mute, m_missed, m_vib;
  int m_k, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_mute = 0; m_missed = 0; m_k = 0; m_cnt = 0;
  endtask

  task automatic model_update(input bit r, input bit v, input bit s, input bit a, input bit c);
    m_missed = 0;
    m_vib    = v;
    if (!r) begin
      m_busy = 0; m_hold = 0;
    end else if (!m_busy) begin
      m_busy = 1; m_hold = 0; m_k = 0; m_mute = 0;
    end else if (!m_hold) begin
      if (a) m_hold = 1;
      else begin
        if (s) m_mute = 1;
        m_k++;
        if (m_k == END_K) begin m_hold = 1; m_missed = 1; end
      end
    end
`ifdef RING_MISSED_COUNT_EN
    if (c) m_cnt = 0;
    else if (m_missed && m_cnt < 255) m_cnt++;
`else
    m_cnt = 0;
`endif
  endtask

  task automatic compare_all();
    bit on;
    on = m_busy && !m_hold && ((m_k % PER) < ON_C) && !m_mute;
    check("ringer", 32'(bus.ringer), 32'(on && !m_vib));
    check("motor", 32'(bus.motor), 32'(on && m_vib));
    check("missed_call", 32'(bus.missed_call), 32'(m_missed));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("missed_count", 32'(bus.missed_count), 32'(m_cnt));
    check("exclusive", 32'(bus.ringer & bus.motor), 32'(0));
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit a, input bit c);
    bus.ring = r; bus.vibrate_mode = v; bus.silence = s; bus.answer = a; bus.clear_missed = c;
    @(posedge clk);
    model_update(r, v, s, a, c);
    #1;
    compare_all();
    bus.silence = 0; bus.answer = 0; bus.clear_missed = 0;
  endtask

  task automatic run_call(input int n, input bit v);
    for (int i = 0; i < n; i++) step(1, v, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.ring = 0; bus.vibrate_mode = 0; bus.silence = 0; bus.answer = 0; bus.clear_missed = 0;
    model_reset();
    m_vib = 0;
    #12;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Basic cadence, then vibrate, both held past timeout
    step(0, 0, 0, 0, 0);
    run_call(15, 0);
    step(0, 0, 0, 0, 0);
    run_call(15, 1);
    step(0, 1, 0, 0, 0);

    // Answer in clock 2 of burst 1
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    run_call(14, 0);
    step(0, 0, 0, 0, 0);

    // Silence in burst 1
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    run_call(14, 0);
    step(0, 0, 0, 0, 0);

    // Mode swap mid-burst, then abort during OFF
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0));
    end
    step(0, 0, 0, 0, 1);

    // Saturation: 257 timeouts, then clear
    for (int n = 0; n < 257; n++) begin
      run_call(END_K + 1, n[0]);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Asynchronous reset mid-burst
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    run_call(6, 1);
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ring_cadence_ctrl.md
# ring_cadence_ctrl

Call-alert sequencer that sits ahead of the ringer/motor actuator stage. It turns a raw level-held incoming-call request into a timed on/off alert cadence and keeps the ringer and the vibration motor mutually exclusive. It also handles user silence and answer events, and flags a missed call after a fixed number of unanswered bursts.

## Interface
Parameters:
- ON_CYCLES, default 4: alert-on duration per burst, in clocks. Must be ≥1.
- OFF_CYCLES, default 3: gap between bursts, in clocks. Must be ≥1.
- MAX_BURSTS, default 2: number of unanswered bursts before timeout. Must be ≥1.

Ports:
- clk  input  1: single clock; all state is updated on its rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- ring  input  1: incoming-call request, level-held while the call is present.
- vibrate_mode  input  1: 1 selects motor, 0 selects ringer. Sampled every clock.
- silence  input  1: single-cycle pulse; mutes the current call.
- answer  input  1: single-cycle pulse; user answered the call.
- ringer  output  1: drive for the audible ringer, registered.
- motor  output  1: drive for the vibration motor, registered.
- missed_call  output  1: single-cycle pulse when a call times out.
- busy  output  1: high whenever state ≠ IDLE.
- missed_count  output  8: saturating count of missed calls.
- clear_missed  input  1: pulse; clears missed_count.

## Operation
- States: IDLE, ON, OFF, HOLD. Per-call registers: timer, burst counter, mute flag.
- IDLE → ON when ring=1. On entry: timer loads ON_CYCLES-1, burst counter 0, mute flag 0.
- ON: timer counts down. When timer=0:
  - if burst counter = MAX_BURSTS-1 → HOLD, pulse missed_call;
  - otherwise → OFF, timer loads OFF_CYCLES-1, burst counter +1.
- OFF: timer counts down. When timer=0 → ON, timer loads ON_CYCLES-1.
- HOLD: outputs off; stays until ring=0, then → IDLE.
- Priority within a cycle, highest first: ring=0 (any state → IDLE, no missed_call) > answer (ON/OFF → HOLD, no missed_call) > silence (sets mute flag, cadence continues) > timer expiry.
- silence and answer are ignored in IDLE and HOLD.
- Output register next-values:
  - ringer = (next state ON) & !mute & !vibrate_mode
  - motor = (next state ON) & !mute & vibrate_mode
  - ringer and motor are never both 1.
- A muted call still times out and still pulses missed_call.
- vibrate_mode changing mid-burst swaps the active actuator on the next edge. No gap cycle and no overlap.
- Counter widths: timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)+1); burst counter width is $clog2(MAX_BURSTS+1).

## Timing
- Reset values: state IDLE; ringer, motor, missed_call, busy, missed_count all 0.
- Reset asserted mid-call: all outputs drop to 0 immediately (asynchronous).
- Latency from ring sampled high to ringer/motor high: 1 clock. Drop latency after ring low: 1 clock.
- Each ON burst drives an output for exactly ON_CYCLES clocks; each gap lasts exactly OFF_CYCLES clocks.
- The last burst is followed directly by HOLD; there is no trailing OFF.
- missed_call is high for exactly one clock, coincident with the first HOLD cycle.
- ring=0 on the same edge as final-burst expiry: goes to IDLE with no missed_call.

## Configuration
- Macro RING_MISSED_COUNT_EN.
- Defined: missed_count increments on each missed_call pulse and saturates at 255. clear_missed zeroes it; clear_missed has priority over a simultaneous increment.
- Undefined: missed_count is tied to 0 and clear_missed is ignored. The port list is unchanged.

## Structure
- Package ring_ctrl_pkg holds the state enum (IDLE/ON/OFF/HOLD) and the default cadence constants.
- One sub-module, ring_cadence_timer: a loadable down-counter with a load value input, load strobe and expire flag. It is instantiated once and shared between the ON and OFF phases.

## Test plan
All scenarios use defaults (ON=4, OFF=3, MAX=2).
- Basic cadence: vibrate_mode=0, ring held high.
  - Required: ringer high 4 clocks, low 3, high 4; then missed_call pulses once; busy stays high until ring drops.
- Vibrate: same stimulus with vibrate_mode=1.
  - Required: motor follows the identical pattern and ringer stays 0 throughout.
- Answer: answer pulse in clock 2 of burst 1.
  - Required: ringer low the next clock, no missed_call, HOLD until ring=0, then IDLE.
- Silence: silence pulse in burst 1.
  - Required: ringer 0 for the rest of the call; missed_call still pulses at the normal time; missed_count=1 with macro defined.
- Mode swap and abort:
  - vibrate_mode toggles mid-burst → ringer/motor swap on the next edge with no overlap;
  - ring drops during OFF → IDLE next clock, no missed_call.
- Reset mid-burst and saturation:
  - reset_n low mid-burst → outputs 0 at once;
  - 256 timeouts → missed_count holds at 255;
  - clear_missed → 0.
